interrupt_timer: RTL and testbench

Programmable interval timer that counts rising edges of the 1 MHz clock produced by the clock generator and raises a level interrupt request to the pipelined CPU's interrupt unit. It runs entirely in the 100 MHz domain. It treats `Clock_1M` as an asynchronous input: the input is synchronised and edge-detected into a single-cycle tick. The CPU programs the timer through a small write port and clears the request with an acknowledge pulse.

---
 rtl/interrupt_timer.sv | 139 +++++++++++++
 tb/tb_interrupt_timer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_timer.sv
// interrupt_timer: interval timer counting synchronised Clock_1M rising edges in the Clock_100M domain.
// Define INT_TIMER_OVERFLOW_EN to build the sticky overflow flag (otherwise overflow is tied to 0).
module interrupt_timer #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned DEFAULT_RELOAD = 1000
) (
    input  logic             Clock_100M,
    input  logic             Reset,
    input  logic             Clock_1M,
    input  logic             wr_en,
    input  logic             wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             int_ack,
    output logic             irq,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             overflow
);
    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_RUN     = 1'b1;
    localparam logic [WIDTH-1:0] RELOAD_RST = WIDTH'(DEFAULT_RELOAD);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3 (edge-detect history)
    logic [2:0]       sync_q;
    logic             tick_s;
    logic             ctrl_wr_s;
    logic             terminal_s;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             irq_q, irq_d;

    assign tick_s    = sync_q[1] & ~sync_q[2];
    assign ctrl_wr_s = wr_en & ~wr_addr;

    // Synchroniser and edge-history flops for the asynchronous 1 MHz input
    always_ff @(posedge Clock_100M or posedge Reset) begin
        if (Reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], Clock_1M};
        end
    end

    // Next-state logic: a control write takes priority over a coincident tick
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        periodic_d = periodic_q;
        terminal_s = 1'b0;
        if (wr_en && wr_addr) begin
            reload_d = wr_data;
        end else begin
            reload_d = reload_q;
        end
        if (ctrl_wr_s) begin
            periodic_d = wr_data[1];
            if (wr_data[0]) begin
                state_d = ST_RUN;
                count_d = reload_q;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (tick_s && (state_q == ST_RUN)) begin
            if (count_q <= ONE) begin
                terminal_s = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = {WIDTH{1'b0}};
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end else begin
            state_d = state_q;
        end
        if (terminal_s) begin
            irq_d = 1'b1;
        end else if (int_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Timer state registers
    always_ff @(posedge Clock_100M or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            count_q    <= {WIDTH{1'b0}};
            reload_q   <= RELOAD_RST;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            irq_q      <= irq_d;
        end
    end

`ifdef INT_TIMER_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Setting wins over a clear written in the same cycle
    always_comb begin
        if (terminal_s && irq_q && !int_ack) begin
            ovf_d = 1'b1;
        end else if (ctrl_wr_s && wr_data[2]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge Clock_100M or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign irq     = irq_q;
    assign count   = count_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_interrupt_timer.sv
// Self-checking bench for interrupt_timer: a behavioural model pushes expected outputs to a scoreboard.
module tb_interrupt_timer;
    logic        clk = 1'b0;
    logic        Reset;
    logic        c1m;
    logic        wr_en;
    logic        wr_addr;
    logic [15:0] wr_data;
    logic        int_ack;
    logic        irq;
    logic [15:0] count;
    logic        running;
    logic        overflow;

`ifdef INT_TIMER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] c;
        logic        i;
        logic        r;
        logic        o;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;

    logic [15:0] m_count, m_reload;
    logic        m_irq, m_run, m_ovf, m_per;

    interrupt_timer #(.WIDTH(16), .DEFAULT_RELOAD(1000)) dut (
        .Clock_100M(clk), .Reset(Reset), .Clock_1M(c1m), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .int_ack(int_ack), .irq(irq), .count(count), .running(running),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_count = 16'd0; m_irq = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_per = 1'b0; m_reload = 16'd1000;
    endtask

    task automatic m_push(input string nm);
        if (nm != "") begin
            sb.push_back('{m_count, m_irq, m_run, m_ovf});
            nm_q.push_back(nm);
        end
    endtask

    task automatic m_ctrl(input logic [15:0] d);
        m_per = d[1];
        if (d[0]) begin
            m_run = 1'b1;
            m_count = m_reload;
        end else begin
            m_run = 1'b0;
        end
        if (OVF_EN && d[2]) m_ovf = 1'b0;
    endtask

    task automatic m_tick(input bit ack);
        bit term;
        term = m_run && (m_count <= 16'd1);
        if (term) begin
            if (OVF_EN && m_irq && !ack) m_ovf = 1'b1;
            m_irq = 1'b1;
            if (m_per) m_count = m_reload;
            else begin
                m_count = 16'd0;
                m_run = 1'b0;
            end
        end else begin
            if (m_run) m_count = m_count - 16'd1;
            if (ack) m_irq = 1'b0;
        end
    endtask

    task automatic wr(input logic a, input logic [15:0] d, input string nm);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a) m_reload = d;
        else m_ctrl(d);
        m_push(nm);
    endtask

    task automatic do_ack(input string nm);
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        m_irq = 1'b0;
        m_push(nm);
    endtask

    // Raise Clock_1M and stop in the cycle where the tick pulse is high
    task automatic tick_rise();
        @(negedge clk);
        c1m = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // mode 0: plain tick, 1: int_ack with tick, 2: control write wd with tick
    task automatic tick_finish(input int mode, input logic [15:0] wd, input string nm);
        if (mode == 1) int_ack = 1'b1;
        if (mode == 2) begin
            wr_en = 1'b1; wr_addr = 1'b0; wr_data = wd;
        end
        if (mode == 2) m_ctrl(wd);
        else m_tick(mode == 1);
        m_push(nm);
        @(negedge clk);
        int_ack = 1'b0;
        wr_en = 1'b0;
        repeat (47) @(negedge clk);
        c1m = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    task automatic tick_1m(input int mode, input logic [15:0] wd, input string nm);
        tick_rise();
        tick_finish(mode, wd, nm);
    endtask

    task automatic pop_cmp();
        exp_t  e;
        string nm;
        e = sb.pop_front();
        nm = nm_q.pop_front();
        total++;
        if ({count, irq, running, overflow} !== {e.c, e.i, e.r, e.o}) begin
            bad++;
            $display("FAIL %s: got count=%0d irq=%b run=%b ovf=%b, want count=%0d irq=%b run=%b ovf=%b",
                     nm, count, irq, running, overflow, e.c, e.i, e.r, e.o);
        end
    endtask

    task automatic test_reset();
        m_reset();
        m_push("reset_held");
        pop_cmp();
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        m_push("after_reset");
        pop_cmp();
    endtask

    task automatic test_periodic();
        wr(1'b1, 16'd3, "");
        wr(1'b0, 16'd3, "per_enable");
        pop_cmp();
        for (int k = 0; k < 6; k++) begin
            tick_rise();
            total++;
            if (count !== m_count) begin
                bad++;
                $display("FAIL per_latency: count=%0d before update edge, want %0d", count, m_count);
            end
            tick_finish(0, 16'd0, "per_tick");
            pop_cmp();
            if (m_irq) begin
                do_ack("per_ack");
                pop_cmp();
            end
        end
        wr(1'b0, 16'd0, "per_stop");
        pop_cmp();
    endtask

    task automatic test_oneshot();
        wr(1'b1, 16'd2, "");
        wr(1'b0, 16'd1, "os_enable");
        pop_cmp();
        tick_1m(0, 16'd0, "os_tick1");
        pop_cmp();
        tick_1m(0, 16'd0, "os_tick2");
        pop_cmp();
        do_ack("os_ack");
        pop_cmp();
        tick_1m(0, 16'd0, "os_idle_tick");
        pop_cmp();
    endtask

    task automatic test_overflow();
        wr(1'b1, 16'd1, "");
        wr(1'b0, 16'd3, "ovf_enable");
        pop_cmp();
        tick_1m(0, 16'd0, "ovf_first");
        pop_cmp();
        tick_1m(0, 16'd0, "ovf_second");
        pop_cmp();
        wr(1'b0, 16'd7, "ovf_clear");
        pop_cmp();
        tick_1m(1, 16'd0, "ack_same_cycle");
        pop_cmp();
        do_ack("ovf_ack");
        pop_cmp();
        wr(1'b0, 16'd0, "");
    endtask

    task automatic test_write_vs_tick();
        wr(1'b1, 16'd4, "");
        wr(1'b0, 16'd3, "wt_enable");
        pop_cmp();
        tick_1m(0, 16'd0, "wt_tick");
        pop_cmp();
        tick_1m(2, 16'd3, "wt_collide");
        pop_cmp();
        wr(1'b0, 16'd0, "");
    endtask

    task automatic test_reload_change();
        wr(1'b1, 16'd10, "");
        wr(1'b0, 16'd3, "rl_enable");
        pop_cmp();
        tick_1m(0, 16'd0, "rl_tick");
        pop_cmp();
        wr(1'b1, 16'd5, "rl_write");
        pop_cmp();
        for (int k = 0; k < 12 && !m_irq; k++) begin
            tick_1m(0, 16'd0, "rl_count");
            pop_cmp();
        end
        total++;
        if (count !== 16'd5) begin
            bad++;
            $display("FAIL rl_next_period: count=%0d, want 5", count);
        end
        do_ack("");
        wr(1'b0, 16'd0, "");
    endtask

    task automatic test_reset_mid();
        wr(1'b1, 16'd1, "");
        wr(1'b0, 16'd3, "");
        tick_1m(0, 16'd0, "");
        wr(1'b1, 16'd9, "");
        wr(1'b0, 16'd3, "");
        tick_1m(0, 16'd0, "");
        tick_1m(0, 16'd0, "rm_pre");
        pop_cmp();
        @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        m_reset();
        m_push("rm_async");
        pop_cmp();
        @(negedge clk);
        Reset = 1'b0;
        wr(1'b0, 16'd1, "rm_enable");
        pop_cmp();
        repeat (20) @(negedge clk);
        m_push("rm_no_tick");
        pop_cmp();
        tick_1m(0, 16'd0, "rm_first_tick");
        pop_cmp();
        wr(1'b0, 16'd0, "");
    endtask

    initial begin
        Reset = 1'b1; c1m = 1'b0; wr_en = 1'b0; wr_addr = 1'b0; wr_data = 16'd0; int_ack = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_periodic();
        test_oneshot();
        test_overflow();
        test_write_vs_tick();
        test_reload_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
